pattern_prbs_transmitter: RTL

Byte-serial transmitter feeding the PRBS-15 link.
- On a start pulse it emits a 32-bit alignment pattern, least-significant byte first, nPattern times back-to-back.
- It then emits PayloadLen bytes of PRBS-15 data.
- It is the transmit-side counterpart of the receive-side pattern detector, which declares lock after nPattern consecutive pattern words.
- Output uses a valid/ready handshake toward the serializer/channel model.

---
 rtl/pattern_pkg.sv | 32 +++
 rtl/prbs15_byte_lfsr.sv | 55 +++++
 rtl/pattern_prbs_transmitter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_pkg
// Description : Shared definitions for the PRBS-15 link pattern TX/RX pair.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PATTERN = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_FINISH  = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_PATTERN  = 32'hAABBCCDD;
    localparam logic [3:0]  DEFAULT_NPATTERN = 4'd4;
    localparam logic [14:0] PRBS15_SEED      = 15'h7FFF;
    // x^15 + x^14 + 1 : feedback from state bits 14 and 13
    localparam logic [14:0] PRBS15_TAPS      = 15'h6000;

    function automatic logic [14:0] prbs15_step(input logic [14:0] s);
        return {s[13:0], ^(s & PRBS15_TAPS)};
    endfunction

    // An all-zero LFSR would lock up, so zero maps to the default seed.
    function automatic logic [14:0] prbs15_fix_seed(input logic [14:0] s);
        return (s == 15'd0) ? PRBS15_SEED : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs15_byte_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : prbs15_byte_lfsr
// Description : PRBS-15 generator producing eight sequence bits per advance.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs15_byte_lfsr
    import pattern_pkg::*;
#(
    parameter logic [14:0] ResetValue = PRBS15_SEED
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        Load,
    input  logic [14:0] LoadValue,
    input  logic        Advance,
    output logic [7:0]  Byte
);

    logic [14:0] state_q;
    logic [14:0] state_d;
    logic [14:0] w_unroll;

    // Bit i of the byte is the (i+1)-th generated bit, so bit0 comes out first.
    always_comb begin : p_unroll
        logic [14:0] s;
        s    = state_q;
        Byte = '0;
        for (int i = 0; i < 8; i++) begin
            s       = prbs15_step(s);
            Byte[i] = s[0];
        end
        w_unroll = s;
    end

    always_comb begin
        state_d = state_q;
        if (Load) begin
            state_d = LoadValue;
        end else if (Advance) begin
            state_d = w_unroll;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ResetValue;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_prbs_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : pattern_prbs_transmitter
// Description : Sends nPattern alignment words then PayloadLen PRBS-15 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_prbs_transmitter
    import pattern_pkg::*;
#(
    parameter int unsigned          BusWidth   = 8,
    parameter int unsigned          NumWidth   = 4,
    parameter logic [31:0]          OutPattern = DEFAULT_PATTERN,
    parameter logic [NumWidth-1:0]  nPattern   = NumWidth'(DEFAULT_NPATTERN),
    parameter int unsigned          LenWidth   = 16,
    parameter logic [LenWidth-1:0]  PayloadLen = LenWidth'(256),
    parameter logic [14:0]          Seed       = PRBS15_SEED
)
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start,
    input  logic                OutReady,
    output logic [BusWidth-1:0] OutData,
    output logic                OutValid,
    output logic                Busy,
    output logic                Done
);

    localparam logic [14:0]         SEED_EFF     = prbs15_fix_seed(Seed);
    localparam logic [NumWidth-1:0] LAST_REP     = nPattern - NumWidth'(1);
    localparam logic [LenWidth-1:0] LAST_PAYLOAD = PayloadLen - LenWidth'(1);

    state_e                state_q,   state_d;
    logic [BusWidth-1:0]   data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic [1:0]            idx_q,     idx_d;
    logic [NumWidth-1:0]   rep_q,     rep_d;
    logic [LenWidth-1:0]   pay_q,     pay_d;

    logic                  w_xfer;
    logic                  w_lfsr_load;
    logic                  w_lfsr_adv;
    logic [7:0]            w_lfsr_byte;

    function automatic logic [7:0] pattern_byte(input logic [1:0] idx);
        return OutPattern[{idx, 3'b000} +: 8];
    endfunction

    prbs15_byte_lfsr #(
        .ResetValue (SEED_EFF)
    ) u_lfsr (
        .CLK       (CLK),
        .RST       (RST),
        .Load      (w_lfsr_load),
        .LoadValue (SEED_EFF),
        .Advance   (w_lfsr_adv),
        .Byte      (w_lfsr_byte)
    );

    assign w_xfer = valid_q & OutReady;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        idx_d       = idx_q;
        rep_d       = rep_q;
        pay_d       = pay_q;
        w_lfsr_load = 1'b0;
        w_lfsr_adv  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d     = ST_PATTERN;
                    data_d      = pattern_byte(2'd0);
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                    idx_d       = 2'd0;
                    rep_d       = '0;
                    pay_d       = '0;
                    w_lfsr_load = 1'b1;
                end
            end

            ST_PATTERN: begin
                if (w_xfer) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        rep_d = rep_q + NumWidth'(1);
                        if (rep_q == LAST_REP) begin
                            if (PayloadLen != '0) begin
                                // The LFSR still holds the seed, so its byte is payload byte 0.
                                state_d    = ST_PAYLOAD;
                                data_d     = w_lfsr_byte;
                                w_lfsr_adv = 1'b1;
                                pay_d      = '0;
                            end else begin
                                state_d = ST_FINISH;
                                data_d  = '0;
                                valid_d = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            data_d = pattern_byte(2'd0);
                        end
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        data_d = pattern_byte(idx_q + 2'd1);
                    end
                end
            end

            ST_PAYLOAD: begin
                if (w_xfer) begin
                    pay_d = pay_q + LenWidth'(1);
                    if (pay_q == LAST_PAYLOAD) begin
                        state_d = ST_FINISH;
                        data_d  = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d     = w_lfsr_byte;
                        w_lfsr_adv = 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                // Start is deliberately ignored here; only Idle accepts a new frame.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                data_d  = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                idx_d   = 2'd0;
                rep_d   = '0;
                pay_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 2'd0;
            rep_q   <= '0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            pay_q   <= pay_d;
        end
    end

    assign OutData  = data_q;
    assign OutValid = valid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
`default_nettype wire
